mul_arbiter: RTL



---
 rtl/mul_arb_pkg.sv | 20 ++
 rtl/mul_arbiter_if.sv | 29 ++
 rtl/mul_arbiter_rr_arbiter.sv | 42 ++++
 rtl/mul_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared state type, multiplier op encodings and op legality check for mul_arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_MUL    = 3'b001;
  localparam logic [2:0] OP_MULH   = 3'b010;
  localparam logic [2:0] OP_MULHSU = 3'b011;
  localparam logic [2:0] OP_MULHU  = 3'b100;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester and multiplier signal bundle for mul_arbiter; slave = arbiter view, master = environment view.
interface mul_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [2:0]        mul_sel;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_ready;
  logic [W-1:0]      mul_res;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, mul_ready, mul_res,
    output req_ready, rsp_valid, rsp_data, mul_sel, mul_a, mul_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, mul_ready, mul_res,
    input  req_ready, rsp_valid, rsp_data, mul_sel, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request after the last accepted index; pointer moves only on accept.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_i,
  input  logic                      accept_i,
  output logic [NREQ-1:0]           grant_o,
  output logic [$clog2(NREQ)-1:0]   grant_idx_o
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = '0;
    found       = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        found         = 1'b1;
      end
    end
  end

  // Reset to the last index so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (accept_i) begin
      ptr_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between NREQ requesters (IDLE/EXEC/RESP sequencer).
// Optional one-entry result cache enabled by defining MUL_ARB_CACHE_EN.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_arbiter_if.slave   bus
);
  localparam int unsigned IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    rsp_q, rsp_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic [2:0]      sel_op;
  logic [W-1:0]    sel_a, sel_b;
  logic            accept;
  logic            hit;
  logic [W-1:0]    hit_res;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (bus.req_valid),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    sel_op = OP_NONE;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op = bus.req_op[3*i +: 3];
        sel_a  = bus.req_a[W*i +: W];
        sel_b  = bus.req_b[W*i +: W];
      end
    end
  end

  assign accept = (state_q == IDLE) && (|grant);

`ifdef MUL_ARB_CACHE_EN
  logic         c_valid_q;
  logic [2:0]   c_op_q;
  logic [W-1:0] c_a_q, c_b_q, c_res_q;

  // Only legal ops are ever cached, so a field match implies a legal op.
  assign hit     = c_valid_q && (c_op_q == sel_op) && (c_a_q == sel_a) && (c_b_q == sel_b);
  assign hit_res = c_res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q <= 1'b0;
      c_op_q    <= OP_NONE;
      c_a_q     <= '0;
      c_b_q     <= '0;
      c_res_q   <= '0;
    end else if (state_q == EXEC && bus.mul_ready) begin
      c_valid_q <= 1'b1;
      c_op_q    <= op_q;
      c_a_q     <= a_q;
      c_b_q     <= b_q;
      c_res_q   <= bus.mul_res;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant_idx;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          // Illegal ops and cache hits bypass the multiplier entirely.
          if (!is_legal_op(sel_op)) begin
            rsp_d   = '0;
            state_d = RESP;
          end else if (hit) begin
            rsp_d   = hit_res;
            state_d = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (bus.mul_ready) begin
          rsp_d   = bus.mul_res;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE) ? grant : '0;
    bus.rsp_valid = '0;
    if (state_q == RESP) begin
      bus.rsp_valid[owner_q] = 1'b1;
    end
    bus.rsp_data = rsp_q;
    bus.mul_sel  = (state_q == EXEC) ? op_q : OP_NONE;
    bus.mul_a    = a_q;
    bus.mul_b    = b_q;
  end

endmodule
